// File: rtl/maj_net_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : maj_net_sequencer_if
//  Description : Program/control/result bundle for maj_net_sequencer.
//                master = controller side, slave = sequencer side.
//  Ports       : cfg_we/cfg_addr/cfg_data  program write
//                num_gates/start/sweep/x   run request
//                busy/done/cfg_err         status
//                out/truth_table           results
//  Revision    : 1.0  initial release
// ============================================================================
interface maj_net_sequencer_if #(
    parameter int OPW = 5,
    parameter int AW  = 4
) ();
    logic                    cfg_we;
    logic [AW-1:0]           cfg_addr;
    logic [3*(OPW+1)-1:0]    cfg_data;
    logic [AW:0]             num_gates;
    logic                    start;
    logic                    sweep;
    logic [6:0]              x;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;
    logic                    out;
    logic [127:0]            truth_table;

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_gates, start, sweep, x,
        input  busy, done, cfg_err, out, truth_table
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_gates, start, sweep, x,
        output busy, done, cfg_err, out, truth_table
    );
endinterface
`default_nettype wire

// File: rtl/maj_net_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : maj_net_sequencer
//  Description : Programmable evaluator for 7-input MAJ3 networks. A single
//                shared MAJ3 unit evaluates one gate per cycle. Single mode
//                returns the last gate's output for one vector; sweep mode
//                walks all 128 vectors and builds the truth table.
//  Ports       : clk, rst (async, active high)
//                bus (slave modport of maj_net_sequencer_if)
//  Revision    : 1.0  initial release
// ============================================================================
module maj_net_sequencer #(
    parameter int MAX_GATES = 16,
    parameter int OPW       = 5,
    parameter int AW        = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    maj_net_sequencer_if.slave   bus
);

    localparam int c_fw = OPW + 1;      // one operand field: {inv, op}
    localparam int c_ew = 3 * c_fw;     // one program entry

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_eval = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]           r_state;
    logic [c_ew-1:0]      r_prog [MAX_GATES];
    logic [MAX_GATES-1:0] r_gate;
    logic [AW-1:0]        r_k;
    logic [AW:0]          r_n;
    logic                 r_sweep;
    logic [6:0]           r_vec;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cfg_err;
    logic                 r_out;
    logic [127:0]         r_tt;

    logic [c_ew-1:0]      w_entry;
    logic [2**OPW-1:0]    w_src;
    logic                 w_a;
    logic                 w_b;
    logic                 w_c;
    logic                 w_maj;
    logic                 w_last;
    logic                 w_n_bad;

    // Operand source map: code 0 = constant 0, 1..7 = x0..x6,
    // 8+k = gate k, everything above the gate range stays 0.
    always_comb begin
        w_src                   = '0;
        w_src[7:1]              = r_vec;
        w_src[8 +: MAX_GATES]   = r_gate;
    end

    assign w_entry = r_prog[r_k];
    assign w_a     = w_src[w_entry[3*c_fw-2 -: OPW]] ^ w_entry[3*c_fw-1];
    assign w_b     = w_src[w_entry[2*c_fw-2 -: OPW]] ^ w_entry[2*c_fw-1];
    assign w_c     = w_src[w_entry[c_fw-2   -: OPW]] ^ w_entry[c_fw-1];
    assign w_maj   = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

    assign w_last  = ({1'b0, r_k} == (r_n - 1'b1));
    assign w_n_bad = (bus.num_gates == '0) ||
                     (bus.num_gates > (AW+1)'(MAX_GATES));

    // Program store. Each entry decodes its own address, so writes to
    // addresses beyond the program depth simply match nothing.
    for (genvar g = 0; g < MAX_GATES; g++) begin : g_prog
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prog[g] <= '0;
            end else if (r_state == c_idle && bus.cfg_we &&
                         bus.cfg_addr == AW'(g)) begin
                r_prog[g] <= bus.cfg_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_gate    <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_sweep   <= 1'b0;
            r_vec     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_out     <= 1'b0;
            r_tt      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        if (w_n_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_state <= c_eval;
                            r_busy  <= 1'b1;
                            r_n     <= bus.num_gates;
                            r_sweep <= bus.sweep;
                            r_vec   <= bus.sweep ? 7'd0 : bus.x;
                            r_gate  <= '0;
                            r_k     <= '0;
                            if (bus.sweep) begin
                                r_tt <= '0;
                            end
                        end
                    end
                end
                c_eval: begin
                    if (w_last) begin
                        if (r_sweep) begin
                            r_tt[r_vec] <= w_maj;
                            // Fresh gate state per vector keeps forward
                            // references reading 0 on every pass.
                            r_gate      <= '0;
                            r_k         <= '0;
                            if (r_vec == 7'd127) begin
                                r_state <= c_done;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_vec <= r_vec + 7'd1;
                            end
                        end else begin
                            r_out   <= w_maj;
                            r_state <= c_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_gate[r_k] <= w_maj;
                        r_k         <= r_k + 1'b1;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.out         = r_out;
    assign bus.truth_table = r_tt;

endmodule
`default_nettype wire
